simon_input_conditioner: RTL and testbench

Front-end stage that sits directly upstream of the Simon game core. It conditions the raw board inputs: it synchronises and debounces the "advance" push-button, and turns each press into a clean, fixed-width pclk pulse. It also synchronises the pattern and level switches and holds them stable around each pclk edge. All Simon core inputs except rst come from this block.

---
 rtl/simon_input_conditioner_pkg.sv | 14 +
 rtl/simon_input_conditioner_if.sv | 22 ++
 rtl/simon_sync2.sv | 23 ++
 rtl/simon_input_conditioner.sv | 128 ++++++++++++
 tb/tb_simon_input_conditioner.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/simon_input_conditioner_pkg.sv
// Shared types and defaults for the Simon input conditioner.
package simon_input_conditioner_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      WAIT_PRESS   = 2'd1,
      PRESSED      = 2'd2,
      WAIT_RELEASE = 2'd3
   } db_state_e;

   localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
   localparam int unsigned DEF_HOLD_CYCLES     = 4;

endpackage

// File: rtl/simon_input_conditioner_if.sv
// Board-side inputs and Simon-core-side outputs of the input conditioner.
interface simon_input_conditioner_if #(
   parameter int unsigned SW_W = 4
);
   logic            btn_raw;
   logic [SW_W-1:0] pattern_raw;
   logic            level_raw;
   logic            pclk_out;
   logic            press_pulse;
   logic [SW_W-1:0] pattern_out;
   logic            level_out;

   modport master (
      output btn_raw, pattern_raw, level_raw,
      input  pclk_out, press_pulse, pattern_out, level_out
   );

   modport slave (
      input  btn_raw, pattern_raw, level_raw,
      output pclk_out, press_pulse, pattern_out, level_out
   );
endinterface

// File: rtl/simon_sync2.sv
// Two-flop synchroniser with synchronous clear, parameterised width.
module simon_sync2 #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] s1_q, s2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= d;
         s2_q <= s1_q;
      end
   end

   assign q = s2_q;
endmodule

// File: rtl/simon_input_conditioner.sv
// Debounces the advance button into a fixed-width pclk pulse and freezes the
// pattern/level switches around each pclk rising edge.
module simon_input_conditioner
   import simon_input_conditioner_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned CNT_W           = 20,
   parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
   parameter int unsigned SW_W            = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   simon_input_conditioner_if.slave io
);
   localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   logic            btn_s, level_s;
   logic [SW_W-1:0] pattern_s;

   simon_sync2 #(.W(1))    u_sync_btn     (.clk(clk), .rst(rst), .d(io.btn_raw),     .q(btn_s));
   simon_sync2 #(.W(SW_W)) u_sync_pattern (.clk(clk), .rst(rst), .d(io.pattern_raw), .q(pattern_s));
   simon_sync2 #(.W(1))    u_sync_level   (.clk(clk), .rst(rst), .d(io.level_raw),   .q(level_s));

   db_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              accept_q, accept_d;
   logic              pclk_q, pclk_d;
   logic              press_pulse_q, press_pulse_d;
   logic [SW_W-1:0]   pattern_q, pattern_d;
   logic              level_q, level_d;
   logic              freeze;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         hold_q        <= '0;
         accept_q      <= 1'b0;
         pclk_q        <= 1'b0;
         press_pulse_q <= 1'b0;
         pattern_q     <= '0;
         level_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         hold_q        <= hold_d;
         accept_q      <= accept_d;
         pclk_q        <= pclk_d;
         press_pulse_q <= press_pulse_d;
         pattern_q     <= pattern_d;
         level_q       <= level_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      accept_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (btn_s) begin
               state_d = WAIT_PRESS;
               cnt_d   = '0;
            end
         end
         WAIT_PRESS: begin
            if (!btn_s) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d  = PRESSED;
               cnt_d    = '0;
               accept_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PRESSED: begin
            if (!btn_s) begin
               state_d = WAIT_RELEASE;
               cnt_d   = '0;
            end
         end
         WAIT_RELEASE: begin
            if (btn_s) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // The accept is registered once so press_pulse and pclk rise together in the
   // cycle after the accept edge, while the switches latch on the accept edge itself.
   always_comb begin
      press_pulse_d = accept_q;
      pclk_d        = pclk_q;
      hold_d        = hold_q;
      if (accept_q) begin
         pclk_d = 1'b1;
         hold_d = HOLD_LAST;
      end else if (pclk_q) begin
         if (hold_q == '0) pclk_d = 1'b0;
         else              hold_d = hold_q - 1'b1;
      end

      freeze    = accept_q | (pclk_q & (hold_q != '0));
      pattern_d = freeze ? pattern_q : pattern_s;
      level_d   = freeze ? level_q   : level_s;
   end

   assign io.pclk_out    = pclk_q;
   assign io.press_pulse = press_pulse_q;
   assign io.pattern_out = pattern_q;
   assign io.level_out   = level_q;
endmodule

// File: tb/tb_simon_input_conditioner.sv
// Directed self-checking bench for simon_input_conditioner (DEBOUNCE_CYCLES=4, HOLD_CYCLES=2).
module tb_simon_input_conditioner;
   logic clk = 1'b0;
   logic rst;

   simon_input_conditioner_if #(.SW_W(4)) io ();

   simon_input_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .CNT_W(3),
      .HOLD_CYCLES(2),
      .SW_W(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .io(io.slave)
   );

   always #5 clk = ~clk;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;
   int unsigned pulse_cnt = 0;
   int unsigned pclk_hi_cnt = 0;
   int unsigned base, pbase;

   always @(negedge clk) begin
      if (io.press_pulse === 1'b1) pulse_cnt++;
      if (io.pclk_out === 1'b1)    pclk_hi_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst            = 1'b1;
      io.btn_raw     = 1'b0;
      io.pattern_raw = 4'b0000;
      io.level_raw   = 1'b0;
      tick(3);
      chk("rst_pclk",    32'(io.pclk_out), 0);
      chk("rst_pp",      32'(io.press_pulse), 0);
      chk("rst_pattern", 32'(io.pattern_out), 0);
      chk("rst_level",   32'(io.level_out), 0);
      chk("rst_state",   32'(dut.state_q), 0);
      rst = 1'b0;
      tick(3);

      // 1: clean press, pulse after edge 7, pclk high after edges 7-8
      base = pulse_cnt;
      io.btn_raw = 1'b1;
      for (int e = 0; e < 10; e++) begin
         tick(1);
         chk($sformatf("t1_pp_e%0d", e),   32'(io.press_pulse), 32'(e == 7));
         chk($sformatf("t1_pclk_e%0d", e), 32'(io.pclk_out), 32'(e == 7 || e == 8));
      end
      tick(40);
      chk("t1_one_pulse", pulse_cnt - base, 1);
      io.btn_raw = 1'b0;
      tick(12);

      // 2: press bounce never accepted
      base  = pulse_cnt;
      pbase = pclk_hi_cnt;
      io.btn_raw = 1'b1; tick(2);
      io.btn_raw = 1'b0; tick(1);
      io.btn_raw = 1'b1; tick(2);
      io.btn_raw = 1'b0; tick(15);
      chk("t2_no_pulse", pulse_cnt - base, 0);
      chk("t2_no_pclk",  pclk_hi_cnt - pbase, 0);
      chk("t2_idle",     32'(dut.state_q), 0);

      // 3: release bounce gives no second pulse; fresh press gives one
      base = pulse_cnt;
      io.btn_raw = 1'b1; tick(12);
      for (int i = 0; i < 6; i++) begin
         io.btn_raw = (i % 2 == 0) ? 1'b0 : 1'b1;
         tick(1);
      end
      io.btn_raw = 1'b0; tick(15);
      chk("t3_rel_bounce", pulse_cnt - base, 1);
      base = pulse_cnt;
      io.btn_raw = 1'b1; tick(12);
      io.btn_raw = 1'b0; tick(12);
      chk("t3_fresh", pulse_cnt - base, 1);

      // 4: switches frozen across the pclk high window
      io.pattern_raw = 4'b0001;
      io.level_raw   = 1'b0;
      tick(5);
      chk("t4_pre", 32'(io.pattern_out), 32'h1);
      io.btn_raw = 1'b1;
      tick(6);
      io.pattern_raw = 4'b1000;
      io.level_raw   = 1'b1;
      for (int e = 6; e < 10; e++) begin
         tick(1);
         chk($sformatf("t4_pat_e%0d", e),  32'(io.pattern_out), (e == 9) ? 32'h8 : 32'h1);
         chk($sformatf("t4_lvl_e%0d", e),  32'(io.level_out),   32'(e == 9));
         chk($sformatf("t4_pclk_e%0d", e), 32'(io.pclk_out),    32'(e == 7 || e == 8));
      end

      // 5: reset mid-hold, then button held through reset yields one pulse
      io.btn_raw = 1'b0;
      tick(12);
      io.btn_raw = 1'b1;
      tick(8);
      chk("t5_pclk_up", 32'(io.pclk_out), 1);
      rst = 1'b1;
      tick(1);
      chk("t5_rst_pclk",    32'(io.pclk_out), 0);
      chk("t5_rst_pp",      32'(io.press_pulse), 0);
      chk("t5_rst_pattern", 32'(io.pattern_out), 0);
      chk("t5_rst_level",   32'(io.level_out), 0);
      rst  = 1'b0;
      base = pulse_cnt;
      for (int e = 0; e < 9; e++) begin
         tick(1);
         chk($sformatf("t5_pp_e%0d", e), 32'(io.press_pulse), 32'(e == 7));
      end
      tick(20);
      chk("t5_one_pulse", pulse_cnt - base, 1);

      // 6: idle tracking, 3-edge latency
      io.btn_raw = 1'b0;
      tick(12);
      io.pattern_raw = 4'b0000;
      tick(5);
      chk("t6_pre", 32'(io.pattern_out), 0);
      pbase = pclk_hi_cnt;
      io.pattern_raw = 4'b1010;
      tick(2);
      chk("t6_e1", 32'(io.pattern_out), 32'h0);
      tick(1);
      chk("t6_e2", 32'(io.pattern_out), 32'hA);
      tick(5);
      chk("t6_no_pclk", pclk_hi_cnt - pbase, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
